// File: rtl/truth_sweep_pkg.sv
// Shared types and sizes for the truth-table sweeper: FSM state encoding
// and the fixed four-input vector/table geometry.
package truth_sweep_pkg;

    localparam int VEC_COUNT = 16;
    localparam int IDX_W     = 4;
    localparam int TABLE_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sweep_settle_timer.sv
// Per-vector settle counter: counts up while enabled and flags expire when
// the count reaches SETTLE_CYCLES; clear has priority over enable.
module sweep_settle_timer
    import truth_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [IDX_W-1:0] SETTLE_LIMIT = IDX_W'(SETTLE_CYCLES);

    logic [IDX_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (r_count == SETTLE_LIMIT);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive 4-input sweeper: drives vectors 0..15, captures y into a truth
// table and compares it to a latched golden mask. Optional per-vector
// diagnostics (fail_count/first_fail) are built when TRUTH_SWEEP_DIAG_EN is defined.
module truth_table_sweeper
    import truth_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [TABLE_W-1:0]  expected,
    input  logic                y,
    output logic                a,
    output logic                b,
    output logic                c,
    output logic                d,
    output logic                busy,
    output logic                done,
    output logic [TABLE_W-1:0]  table_out,
    output logic                match,
    output logic [4:0]          fail_count,
    output logic [IDX_W-1:0]    first_fail
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [TABLE_W-1:0] r_expected_q;
    logic [TABLE_W-1:0] r_table;
    logic               r_busy;
    logic               r_done;
    logic               r_match;

    logic               w_expire;
    logic               w_sample;
    logic               w_accept;
    logic [TABLE_W-1:0] w_table_next;

    // Timer idles cleared outside RUN, so every vector starts from count 0.
    sweep_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_clr    ((r_state != RUN) || w_expire),
        .i_en     (r_state == RUN),
        .o_expire (w_expire)
    );

    assign w_sample = (r_state == RUN) && w_expire;
    assign w_accept = (r_state == IDLE) && start;

    always_comb begin
        w_table_next        = r_table;
        w_table_next[r_idx] = y;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_expected_q <= '0;
            r_table      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_match      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_expected_q <= expected;
                        r_table      <= '0;
                        r_match      <= 1'b0;
                        r_busy       <= 1'b1;
                        r_idx        <= '0;
                        r_state      <= RUN;
                    end
                end
                RUN: begin
                    if (w_sample) begin
                        r_table <= w_table_next;
                        // Compare against the just-captured table so match is valid alongside done.
                        if (r_idx == LAST_IDX) begin
                            r_match <= (w_table_next == r_expected_q);
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign {a, b, c, d} = r_idx;
    assign busy         = r_busy;
    assign done         = r_done;
    assign table_out    = r_table;
    assign match        = r_match;

`ifdef TRUTH_SWEEP_DIAG_EN
    logic [4:0]       r_fail_count;
    logic [IDX_W-1:0] r_first_fail;

    // first_fail is only written while fail_count is still zero, which freezes it after the first miss.
    always_ff @(posedge clk) begin
        if (!rst_n || w_accept) begin
            r_fail_count <= '0;
            r_first_fail <= '0;
        end else if (w_sample && (y != r_expected_q[r_idx])) begin
            r_fail_count <= r_fail_count + 1'b1;
            if (r_fail_count == '0) begin
                r_first_fail <= r_idx;
            end
        end
    end

    assign fail_count = r_fail_count;
    assign first_fail = r_first_fail;
`else
    assign fail_count = '0;
    assign first_fail = '0;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: dut0 sweeps a parity function with
// SETTLE_CYCLES=1, dut1 sweeps a 4-input AND with SETTLE_CYCLES=0.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start1;
    logic [15:0] exp0, exp1;
    logic        y0, y1;
    logic        a0, b0, c0, d0, a1, b1, c1, d1;
    logic        busy0, done0, match0, busy1, done1, match1;
    logic [15:0] tbl0, tbl1;
    logic [4:0]  fc0, fc1;
    logic [3:0]  ff0, ff1;

    always #5 clk = ~clk;

    assign y0 = a0 ^ b0 ^ c0 ^ d0;
    assign y1 = a1 & b1 & c1 & d1;

    truth_table_sweeper #(.SETTLE_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .expected(exp0), .y(y0),
        .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0),
        .table_out(tbl0), .match(match0), .fail_count(fc0), .first_fail(ff0)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1), .y(y1),
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
        .table_out(tbl1), .match(match1), .fail_count(fc1), .first_fail(ff1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] tbl;
        logic        mt;
        logic [4:0]  fc;
        logic [3:0]  ff;
        int          acc;
        int          lat;
    } item_t;

    item_t sb0[$];
    item_t sb1[$];
    item_t it0, it1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic item_t mk(input logic [15:0] tbl, input logic mt, input logic [4:0] fc,
                                 input logic [3:0] ff, input int acc, input int lat);
        item_t it;
`ifndef TRUTH_SWEEP_DIAG_EN
        fc = 5'd0;
        ff = 4'd0;
`endif
        it.tbl = tbl; it.mt = mt; it.fc = fc; it.ff = ff; it.acc = acc; it.lat = lat;
        return it;
    endfunction

    // Monitors: pop one expectation per done pulse.
    always @(negedge clk) begin
        if (done0 === 1'b1) begin
            if (sb0.size() == 0) begin
                chk("dut0_unexpected_done", 32'(done0), 32'd0);
            end else begin
                it0 = sb0.pop_front();
                chk("dut0_table", 32'(tbl0), 32'(it0.tbl));
                chk("dut0_match", 32'(match0), 32'(it0.mt));
                chk("dut0_fail_count", 32'(fc0), 32'(it0.fc));
                chk("dut0_first_fail", 32'(ff0), 32'(it0.ff));
                chk("dut0_done_latency", 32'(cyc - it0.acc), 32'(it0.lat));
                chk("dut0_busy_at_done", 32'(busy0), 32'd1);
                chk("dut0_abcd_at_done", 32'({a0, b0, c0, d0}), 32'hf);
            end
        end
    end

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (sb1.size() == 0) begin
                chk("dut1_unexpected_done", 32'(done1), 32'd0);
            end else begin
                it1 = sb1.pop_front();
                chk("dut1_table", 32'(tbl1), 32'(it1.tbl));
                chk("dut1_match", 32'(match1), 32'(it1.mt));
                chk("dut1_fail_count", 32'(fc1), 32'(it1.fc));
                chk("dut1_first_fail", 32'(ff1), 32'(it1.ff));
                chk("dut1_done_latency", 32'(cyc - it1.acc), 32'(it1.lat));
                chk("dut1_busy_at_done", 32'(busy1), 32'd1);
            end
        end
    end

    // Issue a start to dut0 at a negedge while it is idle; expected is scrambled afterwards.
    task automatic issue0(input logic [15:0] e, input logic [15:0] tbl, input logic mt,
                          input logic [4:0] fc, input logic [3:0] ff);
        start0 = 1'b1;
        exp0   = e;
        sb0.push_back(mk(tbl, mt, fc, ff, cyc, 33));
        @(negedge clk);
        start0 = 1'b0;
        exp0   = ~e;
        chk("dut0_busy_after_start", 32'(busy0), 32'd1);
    endtask

    task automatic wait_done0();
        int n = 0;
        while (done0 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("dut0_done_timeout", 32'(done0), 32'd1);
    endtask

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        exp0   = '0;
        exp1   = '0;
        repeat (3) @(negedge clk);
        chk("rst_abcd0", 32'({a0, b0, c0, d0}), 32'd0);
        chk("rst_busy_done_match0", 32'({busy0, done0, match0}), 32'd0);
        chk("rst_table0", 32'(tbl0), 32'd0);
        chk("rst_diag0", 32'({fc0, ff0}), 32'd0);
        chk("rst_abcd1", 32'({a1, b1, c1, d1}), 32'd0);
        chk("rst_busy_done_match1", 32'({busy1, done1, match1}), 32'd0);
        chk("rst_table1", 32'(tbl1), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Parity against correct, single-miss and all-zero golden tables.
        issue0(16'h6996, 16'h6996, 1'b1, 5'd0, 4'd0);
        wait_done0();
        @(negedge clk);
        chk("dut0_busy_after_done", 32'(busy0), 32'd0);
        chk("dut0_match_holds_idle", 32'(match0), 32'd1);
        issue0(16'h6997, 16'h6996, 1'b0, 5'd1, 4'd0);
        wait_done0();
        @(negedge clk);
        issue0(16'h0000, 16'h6996, 1'b0, 5'd8, 4'd1);
        wait_done0();
        @(negedge clk);

        // AND with zero settle: one vector per cycle.
        start1 = 1'b1;
        exp1   = 16'h8000;
        sb1.push_back(mk(16'h8000, 1'b1, 5'd0, 4'd0, cyc, 17));
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            start1 = 1'b0;
            chk("dut1_vector_step", 32'({a1, b1, c1, d1}), 32'(k));
        end
        @(negedge clk);
        @(negedge clk);

        // Starts during RUN and DONE must be ignored.
        issue0(16'h6996, 16'h6996, 1'b1, 5'd0, 4'd0);
        repeat (10) @(negedge clk);
        start0 = 1'b1;
        exp0   = 16'h0000;
        @(negedge clk);
        start0 = 1'b0;
        wait_done0();
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("dut0_ignored_start_idle", 32'({busy0, a0, b0, c0, d0}), 32'd0);
        repeat (40) @(negedge clk);
        chk("dut0_table_after_ignored", 32'(tbl0), 32'h6996);

        // Reset while vector 7 is driven aborts the sweep.
        issue0(16'h6996, 16'h6996, 1'b1, 5'd0, 4'd0);
        begin
            int n = 0;
            while ({a0, b0, c0, d0} != 4'd7 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) chk("dut0_vec7_timeout", 32'({a0, b0, c0, d0}), 32'd7);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb0.delete();
        chk("midrst_abcd", 32'({a0, b0, c0, d0}), 32'd0);
        chk("midrst_busy_done_match", 32'({busy0, done0, match0}), 32'd0);
        chk("midrst_table", 32'(tbl0), 32'd0);
        chk("midrst_diag", 32'({fc0, ff0}), 32'd0);
        repeat (40) @(negedge clk);
        issue0(16'h6996, 16'h6996, 1'b1, 5'd0, 4'd0);
        wait_done0();
        @(negedge clk);

        // Held start: back-to-back sweeps, expected re-latched each time.
        start0 = 1'b1;
        exp0   = 16'h6996;
        sb0.push_back(mk(16'h6996, 1'b1, 5'd0, 4'd0, cyc, 33));
        @(negedge clk);
        wait_done0();
        exp0 = 16'h6997;
        sb0.push_back(mk(16'h6996, 1'b0, 5'd1, 4'd0, cyc + 1, 33));
        @(negedge clk);
        wait_done0();
        start0 = 1'b0;
        repeat (40) @(negedge clk);

        chk("sb0_drained", 32'(sb0.size()), 32'd0);
        chk("sb1_drained", 32'(sb1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencing controller for the team's four-input combinational function blocks (ports `a`, `b`, `c`, `d` → `y`). On a start request it drives all 16 input combinations in ascending order, waits a programmable settle time per vector, and captures `y` into a 16-bit truth table. It then compares the table against an expected mask and reports pass/fail. It replaces hand-written exhaustive benches and serves as a built-in self-check wrapper around any `comb`-style instance.

## Interface
- `SETTLE_CYCLES`, default 1, extra wait cycles after each vector is driven before `y` is sampled; legal range 0..15.
- `clk`  input  1  single clock; all logic is on the rising edge.
- `rst_n`  input  1  reset, synchronous and active-low.
- `start`  input  1  sweep request; accepted only in IDLE.
- `expected`  input  16  golden truth table; bit k is the expected `y` for vector k; sampled when `start` is accepted.
- `y`  input  1  output of the function under control.
- `a`, `b`, `c`, `d`  output  1 each  drive to the function; `{a,b,c,d}` equals the vector index, with `a` as MSB.
- `busy`  output  1  high from the cycle after start acceptance until the DONE cycle, inclusive.
- `done`  output  1  one-cycle pulse when the sweep completes.
- `table_out`  output  16  captured truth table; bit k holds `y` for vector k.
- `match`  output  1  `table_out == expected_q`; valid from `done` until the next accepted start.
- `fail_count`  output  5  number of mismatching vectors, 0..16 (feature-gated).
- `first_fail`  output  4  lowest mismatching index, 0 if none (feature-gated).

## Operation
- States:
  - IDLE → RUN on `start`.
  - RUN → DONE after vector 15 is sampled.
  - DONE → IDLE unconditionally.
- IDLE:
  - `idx`=0; `{a,b,c,d}`=0.
  - `table_out`, `match`, `fail_count` and `first_fail` hold their last values.
  - On `start`: latch `expected` into `expected_q`; clear `table_out`, `match`, `fail_count`, `first_fail` and the settle counter.
- RUN:
  - `{a,b,c,d}` = `idx`. The settle counter increments every cycle.
  - When counter == `SETTLE_CYCLES`:
    - `table_out[idx] <= y`.
    - Counter clears.
    - If `idx`==15, go to DONE; otherwise `idx++`.
- DONE:
  - `done`=1, `busy`=1, and `match` is updated.
  - Outputs `{a,b,c,d}` hold at 4'b1111.
- `start` in RUN or DONE is ignored and not queued.
- `start` held high re-triggers on the first IDLE cycle.
- `expected` changes after acceptance have no effect.
- `idx` never wraps past 15 within a sweep.

## Timing
- Reset values (reset is synchronous, on the `clk` edge with `rst_n`=0):
  - state IDLE.
  - `a`/`b`/`c`/`d`/`busy`/`done`/`match` = 0.
  - `table_out`=16'h0000, `fail_count`=0, `first_fail`=0.
- Reset mid-sweep aborts the sweep at that edge. No `done` is produced.
- Each vector occupies `SETTLE_CYCLES`+1 cycles. `y` is sampled at the last edge of that window.
- With `start` accepted at edge E0:
  - Vector k is sampled at edge E0 + (k+1)(`SETTLE_CYCLES`+1).
  - `done` is high in the cycle after edge E0 + 16(`SETTLE_CYCLES`+1).
  - `SETTLE_CYCLES`=0 gives 17 cycles from the start edge to `done`. The default of 1 gives 33.
- The earliest next acceptance is the cycle after `done`.
- All outputs are registered; there is no combinational path from `y` or `start` to any output.

## Configuration
- `TRUTH_SWEEP_DIAG_EN` defined:
  - `fail_count` increments at each sampling edge where `y != expected_q[idx]`.
  - `first_fail` captures `idx` on the first such mismatch, then freezes.
  - Both are final when `done` asserts.
- Not defined:
  - `fail_count` and `first_fail` are tied to 0 and no diagnostic registers are built.
  - The ports remain present, and `match` behaves identically.

## Structure
- Package `truth_sweep_pkg`:
  - State enum (IDLE, RUN, DONE).
  - `VEC_COUNT`=16, `IDX_W`=4, `TABLE_W`=16.
- One sub-module, `sweep_settle_timer`: a 4-bit counter with clear/enable that asserts `expire` when count == `SETTLE_CYCLES`.
- The FSM, vector index, capture register and compare logic stay in the top module.

## Test plan
- Parity bench model (y=a^b^c^d), `expected`=16'h6996, `SETTLE_CYCLES`=1, pulse `start`:
  - `done` in cycle 33 after the start edge.
  - `table_out`=16'h6996, `match`=1, `fail_count`=0.
- Same model, `expected`=16'h6997:
  - `match`=0, `fail_count`=1, `first_fail`=0.
  - With `expected`=16'h0000: `fail_count`=8, `first_fail`=1.
- `SETTLE_CYCLES`=0, AND model (y=a&b&c&d):
  - `{a,b,c,d}` steps 0..15 on consecutive cycles.
  - `done` at cycle 17; `table_out`=16'h8000.
- Pulse `start` during RUN and during DONE:
  - No restart; a single `done`; `table_out` is unchanged from the clean run.
- Assert `rst_n`=0 for one edge at vector 7:
  - Next cycle, all outputs are at reset values and the state is IDLE.
  - No `done` pulse; a new `start` completes a full sweep normally.
- Hold `start`=1 continuously:
  - Back-to-back sweeps, each `done` separated by one IDLE cycle.
  - `expected` is re-latched each time.
